// File: rtl/traffic_light_pkg.sv
// Shared definitions for the traffic light controller and its passive monitor:
// phase codes, fault codes, default dwell times and the legal phase order.
package traffic_light_pkg;

  localparam logic [1:0] PH_NONE   = 2'd0;
  localparam logic [1:0] PH_RED    = 2'd1;
  localparam logic [1:0] PH_GREEN  = 2'd2;
  localparam logic [1:0] PH_YELLOW = 2'd3;

  localparam logic [2:0] F_NONE    = 3'd0;
  localparam logic [2:0] F_ILLEGAL = 3'd1;
  localparam logic [2:0] F_SEQ     = 3'd2;
  localparam logic [2:0] F_SHORT   = 3'd3;
  localparam logic [2:0] F_LONG    = 3'd4;

  localparam int DEF_RED_CYCLES    = 50;
  localparam int DEF_GREEN_CYCLES  = 40;
  localparam int DEF_YELLOW_CYCLES = 10;
  localparam int DEF_TOL           = 1;

  // Tracking states share their low bits with the phase they track.
  typedef enum logic [2:0] {
    ST_SYNC   = 3'd0,
    ST_RED    = 3'd1,
    ST_GREEN  = 3'd2,
    ST_YELLOW = 3'd3,
    ST_FAULT  = 3'd4
  } state_t;

  function automatic logic [1:0] next_phase(input logic [1:0] ph);
    case (ph)
      PH_RED:    return PH_GREEN;
      PH_GREEN:  return PH_YELLOW;
      PH_YELLOW: return PH_RED;
      default:   return PH_NONE;
    endcase
  endfunction

endpackage

// File: rtl/tl_led_decoder.sv
// Turns the registered {red, yellow, green} lamp vector into a phase code;
// anything other than exactly one lamp lit is reported as illegal.
module tl_led_decoder
  import traffic_light_pkg::*;
(
  input  logic [2:0] led,
  output logic [1:0] phase,
  output logic       illegal
);

  always_comb begin
    phase   = PH_NONE;
    illegal = 1'b0;
    case (led)
      3'b100:  phase = PH_RED;
      3'b001:  phase = PH_GREEN;
      3'b010:  phase = PH_YELLOW;
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/traffic_light_monitor.sv
// Passive checker for the traffic light lamp interface: locks onto the phase
// sequence, checks order and dwell times, latches the first fault and counts loops.
module traffic_light_monitor
  import traffic_light_pkg::*;
#(
  parameter int RED_CYCLES    = DEF_RED_CYCLES,
  parameter int GREEN_CYCLES  = DEF_GREEN_CYCLES,
  parameter int YELLOW_CYCLES = DEF_YELLOW_CYCLES,
  parameter int TOL           = DEF_TOL,
  parameter int CNT_W         = 16
) (
  input  logic             Clock,
  input  logic             Reset_n,
  input  logic             R_LED,
  input  logic             Y_LED,
  input  logic             G_LED,
  input  logic             Clear,
  output logic [1:0]       Phase,
  output logic             Locked,
  output logic             Fault,
  output logic [2:0]       Fault_Code,
  output logic [CNT_W-1:0] Dwell_Count,
  output logic [CNT_W-1:0] Cycle_Count,
  output logic [2:0]       dbg_state
);

  localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] TOL_W = CNT_W'(TOL);

  state_t           state, state_nxt;
  logic [2:0]       led_q;
  logic [1:0]       dec_phase;
  logic             dec_illegal;
  logic [CNT_W-1:0] dwell, dwell_nxt, dwell_inc;
  logic [CNT_W-1:0] cycles, cycles_nxt;
  logic [CNT_W-1:0] limit, min_dwell, long_dwell;
  logic [2:0]       code, code_nxt, hit;
  logic             locked, locked_nxt;
  logic [1:0]       sync_ph, sync_ph_nxt;
  logic             sync_have, sync_have_nxt;
  logic [1:0]       cur_ph;

  tl_led_decoder u_dec (
    .led     (led_q),
    .phase   (dec_phase),
    .illegal (dec_illegal)
  );

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      led_q     <= 3'b000;
      state     <= ST_SYNC;
      dwell     <= '0;
      cycles    <= '0;
      code      <= F_NONE;
      locked    <= 1'b0;
      sync_ph   <= PH_NONE;
      sync_have <= 1'b0;
    end else begin
      led_q     <= {R_LED, Y_LED, G_LED};
      state     <= state_nxt;
      dwell     <= dwell_nxt;
      cycles    <= cycles_nxt;
      code      <= code_nxt;
      locked    <= locked_nxt;
      sync_ph   <= sync_ph_nxt;
      sync_have <= sync_have_nxt;
    end
  end

  always_comb begin
    cur_ph = state[1:0];
    case (state)
      ST_RED:    limit = CNT_W'(RED_CYCLES);
      ST_GREEN:  limit = CNT_W'(GREEN_CYCLES);
      ST_YELLOW: limit = CNT_W'(YELLOW_CYCLES);
      default:   limit = '0;
    endcase
    min_dwell  = limit - TOL_W;
    long_dwell = limit + TOL_W + ONE;
    dwell_inc  = (dwell == '1) ? dwell : dwell + ONE;

    state_nxt     = state;
    dwell_nxt     = dwell;
    cycles_nxt    = cycles;
    code_nxt      = code;
    locked_nxt    = locked;
    sync_ph_nxt   = sync_ph;
    sync_have_nxt = sync_have;
    hit           = F_NONE;

    // The last legal phase seen is tracked in every state so SYNC can spot a change.
    if (!dec_illegal) begin
      sync_ph_nxt   = dec_phase;
      sync_have_nxt = 1'b1;
    end

    if (Clear) begin
      state_nxt  = ST_SYNC;
      dwell_nxt  = '0;
      code_nxt   = F_NONE;
      locked_nxt = 1'b0;
    end else begin
      case (state)
        ST_SYNC: begin
          if (!dec_illegal && sync_have && dec_phase != sync_ph) begin
            state_nxt  = state_t'({1'b0, dec_phase});
            dwell_nxt  = ONE;
            locked_nxt = 1'b1;
          end
        end
        ST_RED, ST_GREEN, ST_YELLOW: begin
          if (dec_illegal) begin
            hit = F_ILLEGAL;
          end else if (dec_phase != cur_ph) begin
            if (dec_phase != next_phase(cur_ph)) begin
              hit = F_SEQ;
            end else if (dwell < min_dwell) begin
              hit = F_SHORT;
            end else begin
              state_nxt = state_t'({1'b0, dec_phase});
              dwell_nxt = ONE;
              if (state == ST_YELLOW && cycles != '1) cycles_nxt = cycles + ONE;
            end
          end else begin
            dwell_nxt = dwell_inc;
            if (dwell_inc == long_dwell) hit = F_LONG;
          end
        end
        ST_FAULT: ;
        default:  state_nxt = ST_SYNC;
      endcase
      if (hit != F_NONE) begin
        state_nxt = ST_FAULT;
        code_nxt  = hit;
      end
    end
  end

  always_comb begin
    Phase       = dec_phase;
    Locked      = locked;
    Fault       = (state == ST_FAULT);
    Fault_Code  = code;
    Dwell_Count = dwell;
    Cycle_Count = cycles;
    dbg_state   = state;
  end

endmodule

// File: doc/traffic_light_monitor.md
Name: traffic_light_monitor

Overview:
Passive checker on the far end of the traffic_light LED interface. It samples R_LED/Y_LED/G_LED, decodes the active phase and enforces the legal order RED->GREEN->YELLOW->RED. It also checks each phase's dwell time against configured limits. It flags faults with a sticky code and counts completed light cycles; it sits beside the controller on the same Clock domain for use in the testbench and on-chip self-check.

Parameters:
RED_CYCLES, 50, required RED dwell in Clock cycles
GREEN_CYCLES, 40, required GREEN dwell in Clock cycles
YELLOW_CYCLES, 10, required YELLOW dwell in Clock cycles
TOL, 1, allowed +/- deviation in dwell cycles (must be < YELLOW_CYCLES)
CNT_W, 16, width of Dwell_Count and Cycle_Count

Ports:
Clock  input  1  system clock, rising edge
Reset_n  input  1  asynchronous active-low reset
R_LED  input  1  red lamp from controller
Y_LED  input  1  yellow lamp from controller
G_LED  input  1  green lamp from controller
Clear  input  1  synchronous pulse; clears sticky fault and returns FSM to SYNC
Phase  output  2  decoded phase: 0 NONE, 1 RED, 2 GREEN, 3 YELLOW
Locked  output  1  high once the first complete phase boundary has been seen
Fault  output  1  sticky fault flag
Fault_Code  output  3  first fault cause, held while Fault=1
Dwell_Count  output  CNT_W  cycles spent in current phase, saturating
Cycle_Count  output  CNT_W  completed RED->GREEN->YELLOW->RED loops, saturating

Behaviour:
- Reset (async assert, sync deassert internally by design of caller): all outputs 0, FSM=SYNC, input register=3'b000.
- Inputs are registered once. Every decision uses the registered value, so latency is 1 cycle from an LED change to Phase/Dwell update.
- Encoding: exactly one LED high is legal. 000 or more than one high is illegal.
- FSM states: SYNC, RED, GREEN, YELLOW, FAULT.
- SYNC: waits for the first change between two legal encodings, then enters the new phase with Dwell_Count=1 and asserts Locked. No dwell check is made on the partial first phase. Illegal encodings while in SYNC are ignored.
- RED/GREEN/YELLOW: Dwell_Count increments each cycle the encoding is unchanged.
- On a change, the exited phase's dwell D is checked against N (that phase's *_CYCLES).
  - If D < N-TOL: Fault_Code=3 (short).
  - If the next phase is out of order: Fault_Code=2 (sequence).
  - Otherwise enter the next phase with Dwell_Count=1.
- Over-dwell: when Dwell_Count reaches N+TOL+1 with no change, Fault_Code=4 (long). This is flagged immediately, not at exit.
- An illegal encoding in any phase state gives Fault_Code=1.
- Priority when several causes hit in the same cycle: 1 > 2 > 3 > 4.
- Cycle_Count increments on a legal YELLOW->RED exit that passed its dwell check. It saturates at all-ones.
- FAULT: Fault=1 and Fault_Code frozen. Phase keeps decoding live (0 if illegal), and Dwell_Count freezes. Only Clear or Reset_n exits; Clear goes to SYNC with Locked=0 and Fault=0, and Cycle_Count is kept.
- Clear in a non-fault state also returns to SYNC. Clear has no effect in SYNC beyond holding it there.
- Reset mid-phase: immediate return to reset values; Cycle_Count is lost.
- Dwell_Count saturates at all-ones. Since N+TOL < 2^CNT_W, this never masks an over-dwell.

Decomposition:
- Shared package traffic_light_pkg holds:
  - phase encodings (PH_NONE/RED/GREEN/YELLOW)
  - fault codes (F_NONE=0, F_ILLEGAL=1, F_SEQ=2, F_SHORT=3, F_LONG=4)
  - default dwell constants, which traffic_light also uses.
- One sub-module: tl_led_decoder. It is combinational and turns the registered 3-bit LED vector into a phase code plus an illegal flag.

Test Plan:
- Legal loop: R 50, G 40, Y 10, R ... for 3 loops after sync -> Fault=0, Cycle_Count=3, Phase tracks with 1-cycle latency.
- Short green: after lock, G held 38 cycles then Y -> Fault=1, Fault_Code=3 one cycle after the Y sample. G held 39 -> no fault.
- Stuck yellow: Y held indefinitely -> Fault=1, Fault_Code=4 when Dwell_Count reaches 12.
- Bad order: R then Y directly -> Fault_Code=2. Drive R+G both high simultaneously -> Fault_Code=1, which also wins over a coincident short-dwell cause.
- Clear/reset: while faulted pulse Clear -> Fault=0, Locked=0, Cycle_Count retained. Reset_n low mid-GREEN -> all outputs 0 asynchronously, before the next edge.
